// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter for a dual-clock FIFO (read clock domain).
// Issues FIFO reads from the empty flag, absorbs the FIFO memory's one-cycle
// registered read latency and presents the words as a valid/ready stream
// through a 2-entry skid buffer.
//
// Buffer occupancy FSM: S_EMPTY / S_ONE / S_TWO. r_pend marks a read issued
// last cycle whose data is on fifo_r_data this cycle. A read is only issued
// when the buffer is guaranteed room for it, so occupancy plus in-flight
// reads never exceeds two.
//
// Handshake: a word transfers on a rising edge of r_clk where m_valid and
// m_ready are both 1. m_valid/m_data hold steady until that transfer happens.
//
// Optional feature: define FIFO_RD_STREAM_CNT_EN to add the CNT_WIDTH-bit
// word_cnt port counting accepted words (wraps modulo 2^CNT_WIDTH).
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8
`ifdef FIFO_RD_STREAM_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  r_clk,
  input  logic                  r_rstn,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_STREAM_CNT_EN
  , output logic [CNT_WIDTH-1:0] word_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_e;

  occ_e                  r_state;
  occ_e                  w_state_nxt;
  logic                  r_pend;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [DATA_WIDTH-1:0] w_head_nxt;
  logic [DATA_WIDTH-1:0] w_tail_nxt;
  logic [1:0]            w_occ;
  logic [2:0]            w_level;
  logic                  w_pop;
  logic                  w_arrival;

  // Occupancy after this cycle's pop, counting the word already in flight.
  assign w_occ     = r_state;
  assign w_pop     = r_valid & m_ready;
  assign w_arrival = r_pend;
  assign w_level   = {1'b0, w_occ} + {2'b00, r_pend} - {2'b00, w_pop};

  // Read only when the returned word is sure to find a free slot; the m_ready
  // term lets a read go out in the same cycle the head is accepted.
  assign fifo_r_en = r_rstn & ~fifo_empty & (w_level < 3'd2);

  assign m_valid = r_valid;
  assign m_data  = r_head;

  // Next-state and buffer-entry update from (arrival, pop).
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    case (r_state)
      S_EMPTY: begin
        if (w_arrival) begin
          w_state_nxt = S_ONE;
          w_head_nxt  = fifo_r_data;
        end
      end
      S_ONE: begin
        case ({w_arrival, w_pop})
          2'b10: begin
            w_state_nxt = S_TWO;
            w_tail_nxt  = fifo_r_data;
          end
          2'b01: w_state_nxt = S_EMPTY;
          2'b11: w_head_nxt  = fifo_r_data;
          default: ;
        endcase
      end
      S_TWO: begin
        // An arrival cannot happen here: reads are throttled to keep room.
        if (w_pop) begin
          w_state_nxt = S_ONE;
          w_head_nxt  = r_tail;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // State, in-flight flag, valid and buffer registers.
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      r_state <= S_EMPTY;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= fifo_r_en;
      r_valid <= (w_state_nxt != S_EMPTY);
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] r_word_cnt;

  // Accepted-word counter, wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign word_cnt = r_word_cnt;
`endif

endmodule
